// File: rtl/send_queue.sv
// In-order send queue: buffers decoder send requests, issues them to the network,
// and returns one completion record (register, passthrough, value 0) per accepted message.
module send_queue #(
  parameter int DEPTH         = 4,
  parameter int XLEN          = 32,
  parameter int PASSTHROUGH_W = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              request_decoder_send_queue_valid,
  output logic                              send_queue_request_decoder_ready,
  input  logic [2*XLEN+5+PASSTHROUGH_W-1:0] request_decoder_send_queue_data,
  output logic                              send_queue_network_valid,
  input  logic                              network_send_queue_ready,
  output logic [2*XLEN-1:0]                 send_queue_network_data,
  output logic                              send_queue_writeback_valid,
  input  logic                              writeback_send_queue_ready,
  output logic [5+PASSTHROUGH_W+XLEN-1:0]   send_queue_writeback_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int MSG_W = 2 * XLEN;
  localparam int REQ_W = MSG_W + 5 + PASSTHROUGH_W;

  typedef logic [REQ_W-1:0] req_t;

  // Entry layout (MSB first): {meta, data, register[4:0], passthrough}.
  function automatic logic [MSG_W-1:0] entry_msg(input req_t e);
    return e[REQ_W-1 -: MSG_W];
  endfunction

  function automatic logic [4:0] entry_reg(input req_t e);
    return e[PASSTHROUGH_W +: 5];
  endfunction

  function automatic logic [PASSTHROUGH_W-1:0] entry_pt(input req_t e);
    return e[PASSTHROUGH_W-1:0];
  endfunction

  req_t                     mem_q [DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [4:0]               wb_reg_q;
  logic [PASSTHROUGH_W-1:0] wb_pt_q;

  req_t head;
  logic wb_free;
  logic push;
  logic pop;

  assign head = mem_q[rd_ptr_q];

  // Handshakes: every valid/ready is gated by rst_n so nothing fires during reset.
  always_comb begin
    wb_free                          = !wb_valid_q || writeback_send_queue_ready;
    send_queue_request_decoder_ready = rst_n && (count_q != CNT_W'(DEPTH));
    send_queue_network_valid         = rst_n && (count_q != '0) && wb_free;
    send_queue_writeback_valid       = rst_n && wb_valid_q;
    push = request_decoder_send_queue_valid && send_queue_request_decoder_ready;
    pop  = send_queue_network_valid && network_send_queue_ready;
  end

  assign send_queue_network_data   = entry_msg(head);
  assign send_queue_writeback_data = {wb_reg_q, wb_pt_q, {XLEN{1'b0}}};

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wb_valid_d = wb_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A pop reloads the record even while the previous one drains this cycle.
    if (pop) begin
      wb_valid_d = 1'b1;
    end else if (wb_valid_q && writeback_send_queue_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q and wb_valid_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= request_decoder_send_queue_data;
    if (pop) begin
      wb_reg_q <= entry_reg(head);
      wb_pt_q  <= entry_pt(head);
    end
  end

endmodule

// File: tb/tb_send_queue.sv
// Directed bench for send_queue: reset, single send, fill/full, writeback backpressure,
// streaming, push/pop across pointer wrap and reset mid-operation.
module tb_send_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int PT_W  = 8;

  logic                     clk;
  logic                     rst_n;
  logic                     req_valid;
  logic                     req_ready;
  logic [2*XLEN+5+PT_W-1:0] req_data;
  logic                     net_valid;
  logic                     net_ready;
  logic [2*XLEN-1:0]        net_data;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [5+PT_W+XLEN-1:0]   wb_data;

  int errors = 0;
  int checks = 0;
  int n_net  = 0;
  int n_wb   = 0;

  send_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PASSTHROUGH_W(PT_W)) dut (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .request_decoder_send_queue_valid (req_valid),
    .send_queue_request_decoder_ready (req_ready),
    .request_decoder_send_queue_data  (req_data),
    .send_queue_network_valid         (net_valid),
    .network_send_queue_ready         (net_ready),
    .send_queue_network_data          (net_data),
    .send_queue_writeback_valid       (wb_valid),
    .writeback_send_queue_ready       (wb_ready),
    .send_queue_writeback_data        (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*XLEN+5+PT_W-1:0] req(input int k);
    return {32'(k), 32'(256 + k), 5'(k), 8'(16 + k)};
  endfunction

  function automatic logic [2*XLEN-1:0] msg(input int k);
    return {32'(k), 32'(256 + k)};
  endfunction

  function automatic logic [5+PT_W+XLEN-1:0] rec(input int k);
    return {5'(k), 8'(16 + k), 32'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_data  = req(99);
    net_ready = 1'b1;
    wb_ready  = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_nvalid", net_valid, 0);
    chk("rst_wvalid", wb_valid, 0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_nvalid", net_valid, 0);

    // Single send
    req_valid = 1'b1;
    req_data  = {32'h11, 32'hAA, 5'd5, 8'h3};
    #1;
    chk("single_no_bypass", net_valid, 0);
    tick();
    req_valid = 1'b0;
    #1;
    chk("single_nvalid", net_valid, 1);
    chk("single_ndata", net_data, {32'h11, 32'hAA});
    chk("single_wvalid0", wb_valid, 0);
    tick();
    #1;
    chk("single_wvalid", wb_valid, 1);
    chk("single_wdata", wb_data, {5'd5, 8'h3, 32'h0});
    chk("single_empty", net_valid, 0);
    tick();
    #1;
    chk("single_wdrain", wb_valid, 0);

    // Fill to full with the network stalled
    net_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      req_valid = 1'b1;
      req_data  = req(k);
      #1;
      chk("fill_ready", req_ready, 1);
      tick();
    end
    req_data = req(5);
    #1;
    chk("full_ready", req_ready, 0);
    chk("full_nvalid", net_valid, 1);
    chk("full_head", net_data, msg(1));
    tick();
    #1;
    chk("full_ready_hold", req_ready, 0);
    req_valid = 1'b0;
    net_ready = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_nvalid", net_valid, 1);
      chk("drain_ndata", net_data, msg(k));
      tick();
      #1;
      chk("drain_wvalid", wb_valid, 1);
      chk("drain_wdata", wb_data, rec(k));
      if (k == 1) chk("ready_after_pop", req_ready, 1);
    end
    chk("fifth_not_taken", net_valid, 0);
    tick();
    #1;
    chk("drain_wdone", wb_valid, 0);

    // Writeback backpressure with two entries queued
    net_ready = 1'b0;
    wb_ready  = 1'b0;
    for (int k = 5; k <= 6; k++) begin
      req_valid = 1'b1;
      req_data  = req(k);
      tick();
    end
    req_valid = 1'b0;
    net_ready = 1'b1;
    #1;
    chk("bp_nvalid", net_valid, 1);
    chk("bp_ndata", net_data, msg(5));
    tick();
    #1;
    chk("bp_wvalid", wb_valid, 1);
    chk("bp_wdata", wb_data, rec(5));
    chk("bp_nblocked", net_valid, 0);
    tick();
    #1;
    chk("bp_nblocked2", net_valid, 0);
    chk("bp_whold", wb_data, rec(5));
    wb_ready = 1'b1;
    #1;
    chk("bp_release_nvalid", net_valid, 1);
    chk("bp_release_ndata", net_data, msg(6));
    tick();
    #1;
    chk("bp_reload_wvalid", wb_valid, 1);
    chk("bp_reload_wdata", wb_data, rec(6));
    chk("bp_empty", net_valid, 0);
    tick();
    #1;
    chk("bp_wdone", wb_valid, 0);

    // Streaming: one push per cycle for 16 cycles
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        req_valid = 1'b1;
        req_data  = req(20 + i);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      chk("stream_nvalid", net_valid, (i >= 1 && i <= 16));
      chk("stream_wvalid", wb_valid, (i >= 2 && i <= 17));
      chk("stream_ready", req_ready, 1);
      if (net_valid && net_ready) begin
        chk("stream_ndata", net_data, msg(20 + n_net));
        n_net++;
      end
      if (wb_valid && wb_ready) begin
        chk("stream_wdata", wb_data, rec(20 + n_wb));
        n_wb++;
      end
      tick();
    end
    chk("stream_net_count", n_net, 16);
    chk("stream_wb_count", n_wb, 16);

    // Push and pop together at count=2, straddling the pointer wrap
    net_ready = 1'b0;
    for (int k = 40; k <= 41; k++) begin
      req_valid = 1'b1;
      req_data  = req(k);
      tick();
    end
    req_data  = req(42);
    net_ready = 1'b1;
    #1;
    chk("pp_ndata0", net_data, msg(40));
    tick();
    req_data = req(43);
    #1;
    chk("pp_ndata1", net_data, msg(41));
    chk("pp_wdata0", wb_data, rec(40));
    chk("pp_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("pp_ndata2", net_data, msg(42));
    tick();
    #1;
    chk("pp_nvalid3", net_valid, 1);
    chk("pp_ndata3", net_data, msg(43));
    tick();
    #1;
    chk("pp_empty", net_valid, 0);
    tick();

    // Reset mid-operation: 3 entries queued plus a pending writeback
    net_ready = 1'b0;
    wb_ready  = 1'b0;
    for (int k = 50; k <= 53; k++) begin
      req_valid = 1'b1;
      req_data  = req(k);
      tick();
    end
    req_valid = 1'b0;
    net_ready = 1'b1;
    tick();
    net_ready = 1'b0;
    #1;
    chk("mid_wvalid", wb_valid, 1);
    chk("mid_full_ready", req_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_wvalid", wb_valid, 0);
    tick();
    rst_n     = 1'b1;
    net_ready = 1'b1;
    wb_ready  = 1'b1;
    #1;
    chk("mid_after_nvalid", net_valid, 0);
    chk("mid_after_wvalid", wb_valid, 0);
    chk("mid_after_ready", req_ready, 1);
    req_valid = 1'b1;
    req_data  = req(60);
    tick();
    req_valid = 1'b0;
    #1;
    chk("mid_new_nvalid", net_valid, 1);
    chk("mid_new_ndata", net_data, msg(60));
    tick();
    #1;
    chk("mid_new_wdata", wb_data, rec(60));
    chk("mid_new_alone", net_valid, 0);
    tick();
    #1;
    chk("mid_new_wdone", wb_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
